// File: rtl/reduce_combine.sv
// reduce_combine: receive-side reduction engine.
// Merges children-tagged reduction packets that share a {contextId, tag} key
// in a small table, combines their payloads with the packet op code, and
// emits one flit once the expected number of arrivals has been combined.
// Optional feature macro: REDUCE_TIMEOUT_EN (per-entry idle timeout flush).
module reduce_combine #(
  parameter int         FlitWidth     = 73,
  parameter int         ChildrenWidth = 3,
  parameter int         PayloadWidth  = 32,
  parameter int         NumEntries    = 4,
  parameter logic [2:0] rank_x        = 3'b0,
  parameter logic [2:0] rank_y        = 3'b0,
  parameter logic [2:0] rank_z        = 3'b0,
  parameter int         TimeoutCycles = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitWidth+ChildrenWidth-1:0] in_packet,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [FlitWidth-1:0]               out_packet,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(NumEntries):0]        entries_used,
  output logic                               err_op
);

  localparam int PW     = PayloadWidth;
  localparam int IdxW   = $clog2(NumEntries);
  localparam int CntW   = IdxW + 1;
  localparam int OpLo   = PW;
  localparam int AlgLo  = PW + 4;
  localparam int TagLo  = PW + 6;
  localparam int CtxLo  = PW + 14;
  localparam int SrcLo  = PW + 22;
  localparam int DstLo  = PW + 31;
  localparam int VldBit = PW + 40;

  typedef struct packed {
    logic [7:0]               ctx;
    logic [7:0]               tag;
    logic [8:0]               dst;
    logic [1:0]               alg;
    logic [3:0]               op;
    logic [PW-1:0]            acc;
    logic [ChildrenWidth-1:0] rem;
  } entry_t;

  // Input field extraction
  logic [ChildrenWidth-1:0] in_children;
  logic                     in_flit_vld;
  logic [8:0]               in_dst;
  logic [7:0]               in_ctx;
  logic [7:0]               in_tag;
  logic [1:0]               in_alg;
  logic [3:0]               in_op;
  logic [PW-1:0]            in_pay;
  logic [15:0]              in_key;
  logic                     unused_src;

  assign in_children = in_packet[FlitWidth +: ChildrenWidth];
  assign in_flit_vld = in_packet[VldBit];
  assign in_dst      = in_packet[DstLo +: 9];
  assign in_ctx      = in_packet[CtxLo +: 8];
  assign in_tag      = in_packet[TagLo +: 8];
  assign in_alg      = in_packet[AlgLo +: 2];
  assign in_op       = in_packet[OpLo +: 4];
  assign in_pay      = in_packet[PW-1:0];
  assign in_key      = {in_ctx, in_tag};
  // The sender's coordinates are replaced by our own rank on output.
  assign unused_src  = ^in_packet[SrcLo +: 9];

  // Table state
  entry_t                tbl_q [NumEntries];
  logic [NumEntries-1:0] valid_q, valid_d;
  logic                  out_valid_q, out_valid_d;
  logic [FlitWidth-1:0]  out_packet_q, out_packet_d;
  logic                  err_op_q;

  // Control
  logic            hit, free_found;
  logic [IdxW-1:0] hit_idx, free_idx;
  logic            out_stall, take, exp_one;
  logic            do_leaf, do_alloc, do_match, match_done, complete, op_bad;
  entry_t          cur, new_ent, fl_ent;
  logic [PW-1:0]   merged;
  logic            flush;
  logic [IdxW-1:0] flush_idx;

  // Payload combine; unsupported op codes fall back to sum.
  function automatic logic [PW-1:0] combine(input logic [3:0] op,
                                            input logic [PW-1:0] a,
                                            input logic [PW-1:0] b);
    case (op)
      4'd1:    combine = (a > b) ? a : b;
      4'd2:    combine = (a < b) ? a : b;
      4'd3:    combine = a & b;
      4'd4:    combine = a | b;
      4'd5:    combine = a ^ b;
      4'd6:    combine = a * b;
      default: combine = a + b;
    endcase
  endfunction

  function automatic logic [FlitWidth-1:0] make_flit(input logic [7:0]    ctx,
                                                     input logic [7:0]    tag,
                                                     input logic [8:0]    dst,
                                                     input logic [1:0]    alg,
                                                     input logic [3:0]    op,
                                                     input logic [PW-1:0] pay);
    make_flit = {1'b1, dst, rank_z, rank_y, rank_x, ctx, tag, alg, op, pay};
  endfunction

  // Key lookup and lowest-index free entry search
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (valid_q[i] && ({tbl_q[i].ctx, tbl_q[i].tag} == in_key)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  // Accept decision and classification of the incoming packet
  always_comb begin
    out_stall  = out_valid_q && !out_ready;
    in_ready   = !out_stall && (hit || free_found);
    take       = in_valid && in_ready && in_flit_vld;
    exp_one    = (in_children <= ChildrenWidth'(1));
    do_leaf    = take && !hit && exp_one;
    do_alloc   = take && !hit && !exp_one;
    do_match   = take && hit;
    cur        = tbl_q[hit_idx];
    merged     = combine(cur.op, cur.acc, in_pay);
    match_done = do_match && (cur.rem == ChildrenWidth'(1));
    complete   = do_leaf || match_done;
    op_bad     = take && ((in_op > 4'd6) || (hit && (in_op != cur.op)));
    new_ent    = '{ctx: in_ctx, tag: in_tag, dst: in_dst, alg: in_alg, op: in_op,
                   acc: in_pay, rem: in_children - ChildrenWidth'(1)};
  end

`ifdef REDUCE_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] idle_q [NumEntries];

  // Pick the lowest-index expired entry when completion and output allow it
  always_comb begin
    flush     = 1'b0;
    flush_idx = '0;
    if (!complete && !out_stall) begin
      for (int i = NumEntries - 1; i >= 0; i--) begin
        if (valid_q[i] && (idle_q[i] == TW'(TimeoutCycles)) &&
            !(do_match && (hit_idx == IdxW'(i)))) begin
          flush     = 1'b1;
          flush_idx = IdxW'(i);
        end
      end
    end
  end

  // Per-entry idle counters, cleared on allocation or match, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumEntries; i++) idle_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        if ((do_alloc && (free_idx == IdxW'(i))) || (do_match && (hit_idx == IdxW'(i))))
          idle_q[i] <= '0;
        else if (valid_q[i] && (idle_q[i] != TW'(TimeoutCycles)))
          idle_q[i] <= idle_q[i] + TW'(1);
      end
    end
  end
`else
  assign flush     = 1'b0;
  assign flush_idx = '0;
`endif

  // Next state of entry valid bits and the output register
  always_comb begin
    // NOTE: combinational next-state logic uses blocking '=' so later lines
    // see earlier updates; registers below use non-blocking '<=' only.
    fl_ent       = tbl_q[flush_idx];
    valid_d      = valid_q;
    out_valid_d  = out_valid_q;
    out_packet_d = out_packet_q;
    if (do_alloc)   valid_d[free_idx]  = 1'b1;
    if (match_done) valid_d[hit_idx]   = 1'b0;
    if (flush)      valid_d[flush_idx] = 1'b0;
    if (out_ready)  out_valid_d = 1'b0;
    if (do_leaf) begin
      out_valid_d  = 1'b1;
      out_packet_d = make_flit(in_ctx, in_tag, in_dst, in_alg, in_op, in_pay);
    end else if (match_done) begin
      out_valid_d  = 1'b1;
      out_packet_d = make_flit(cur.ctx, cur.tag, cur.dst, cur.alg, cur.op, merged);
    end else if (flush) begin
      out_valid_d  = 1'b1;
      out_packet_d = make_flit(fl_ent.ctx, fl_ent.tag, fl_ent.dst, fl_ent.alg, 4'hF, fl_ent.acc);
    end
  end

  // Control registers: entry valid bits, output flit, error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
      err_op_q     <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      out_valid_q  <= out_valid_d;
      out_packet_q <= out_packet_d;
      err_op_q     <= op_bad;
    end
  end

  // Entry payload storage
  // NOTE: the table contents carry no reset; an entry's data is only ever
  // read while its valid bit (which is reset) is set.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      tbl_q[free_idx] <= new_ent;
    end else if (do_match) begin
      tbl_q[hit_idx].acc <= merged;
      tbl_q[hit_idx].rem <= cur.rem - ChildrenWidth'(1);
    end
  end

  // Live-entry count
  always_comb begin
    entries_used = '0;
    for (int i = 0; i < NumEntries; i++) entries_used = entries_used + CntW'(valid_q[i]);
  end

  assign out_valid  = out_valid_q;
  assign out_packet = out_packet_q;
  assign err_op     = err_op_q;

endmodule
